vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible pixels per line; H_TOTAL 800 ticks per line; H_SYNC 96 hsync pulse width; H_POST 48 ticks from hsync trailing edge to first visible pixel.
REQ-002 Parameters (cont.): V_ACTIVE 480 visible lines; V_TOTAL 525 lines per frame; V_SYNC 2; V_POST 10 lines from vsync trailing edge to first visible line; SYNC_POL 1 (sync asserted level); LOCK_FRAMES 2.
REQ-003 Port clk_100MHz, in, 1: single system clock; all logic on its rising edge.
REQ-004 Port reset, in, 1: asynchronous, active-low reset.
REQ-005 Port p_tick, in, 1: pixel-rate enable; hsync, vsync and rgb_in are sampled only on clocks where p_tick=1.
REQ-006 Port hsync, in, 1: horizontal sync; vsync, in, 1: vertical sync. Both are clk_100MHz-synchronous, so no synchronizer.
REQ-007 Port rgb_in, in, 12: pixel colour, sampled on the same tick as the syncs.
REQ-008 Port x, out, 10 and y, out, 10: recovered pixel coordinates of pix_rgb.
REQ-009 Port pix_rgb, out, 12: captured pixel; pix_valid, out, 1: one-clock strobe qualifying x/y/pix_rgb.
REQ-010 Port frame_start, out, 1: strobe coincident with the pix_valid for x=0,y=0.
REQ-011 Port locked, out, 1: timing lock; err, out, 1: sticky timing error; err_cnt, out, 8: saturating error count.

Function
REQ-012 Tick processing: the block SHALL evaluate input edges and counters only on clocks with p_tick=1; on other clocks all state SHALL hold and strobes SHALL be 0.
REQ-013 Edge detection: a sync leading edge is a tick where the sync equals SYNC_POL and the previous sampled value did not.
REQ-014 hcnt (11 b): SHALL be 0 on a tick carrying an hsync leading edge; otherwise it SHALL increment, saturating at 2047.
REQ-015 vline (10 b): SHALL be 0 on a vsync leading edge and increment, saturating at 1023, on each hsync leading edge.
REQ-016 Simultaneous vsync and hsync leading edges SHALL leave vline=1.
REQ-017 Active region: hcnt in [H_SYNC+H_POST, H_SYNC+H_POST+H_ACTIVE-1] and vline in [V_SYNC+V_POST, V_SYNC+V_POST+V_ACTIVE-1].
REQ-018 Coordinate mapping: x=hcnt-(H_SYNC+H_POST); y=vline-(V_SYNC+V_POST).
REQ-019 Capture: for an active tick while locked=1, on the next clock the block SHALL assert pix_valid=1 for exactly one clock with x, y and pix_rgb=rgb_in (1-clock latency); x/y/pix_rgb SHALL hold until the next pix_valid.
REQ-020 Line check: at each hsync leading edge other than the first after reset or after entering SEARCH, the previous hcnt+1 SHALL equal H_TOTAL; otherwise it is a line error.
REQ-021 Frame check: at each vsync leading edge other than the first after reset or after entering SEARCH, vline SHALL equal V_TOTAL at the moment of the edge; otherwise it is a frame error.
REQ-022 FSM state SEARCH: the first vsync leading edge SHALL go to TRACK with good=0.
REQ-023 FSM state TRACK: each error-free vsync-to-vsync frame SHALL increment good; reaching LOCK_FRAMES SHALL go to LOCKED.
REQ-024 FSM state LOCKED: locked=1.
REQ-025 Any line or frame error in TRACK or LOCKED SHALL go to SEARCH, clear good, and deassert locked on the clock following the erroring tick.
REQ-026 Each error SHALL set err (sticky until reset) and increment err_cnt, saturating at 255.
REQ-027 Errors in SEARCH SHALL NOT be counted.
REQ-028 A pixel whose tick also produces an error SHALL NOT be emitted.

Reset
REQ-029 While reset=0, the block SHALL immediately force: FSM=SEARCH; hcnt, vline, good = 0; previous-sync registers = not-asserted.
REQ-030 While reset=0, all outputs SHALL be 0: x, y, pix_rgb, pix_valid, frame_start, locked, err, err_cnt.
REQ-031 Reset assertion mid-line or mid-frame SHALL abort with no further strobes.
REQ-032 After release, the block SHALL require the full SEARCH→TRACK→LOCKED sequence.

Verification
REQ-033 Reset check: assert reset=0 mid-frame with locked=1 -> within the same clock all outputs 0; after release, no pix_valid before the 3rd vsync leading edge.
REQ-034 Nominal lock: drive nominal 800x525 timing with p_tick every 4th clock -> locked rises 1 clk after the tick of the 3rd vsync leading edge; the next frame yields exactly 307200 pix_valid; the first has x=0, y=0, frame_start=1; the last has x=639, y=479.
REQ-035 Pattern capture: rgb_in = {x[3:0], y[3:0], 4'hA} -> every pix_valid shows matching pix_rgb, x and y.
REQ-036 Line error and relock: one line of 799 ticks while LOCKED -> locked=0, err=1, err_cnt=1; relock after 2 further good frames; no pix_valid in between.
REQ-037 p_tick stall: p_tick held 0 for 1000 clocks while syncs toggle -> no state change, no strobes; timing resumes unchanged afterwards.
REQ-038 Error saturation: 300 consecutive bad frames, each re-entering TRACK -> err_cnt saturates at 255.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel coordinates, pixel data and lock status from VGA sync timing
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_POST      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_POST      = 10,
    parameter bit SYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [11:0] pix_rgb,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int H_START = H_SYNC + H_POST;
    localparam int V_START = V_SYNC + V_POST;

    localparam logic [10:0] H_FIRST    = 11'(H_START);
    localparam logic [10:0] H_LAST     = 11'(H_START + H_ACTIVE - 1);
    localparam logic [10:0] H_LINE_END = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_FIRST    = 10'(V_START);
    localparam logic [9:0]  V_LAST     = 10'(V_START + V_ACTIVE - 1);
    localparam logic [9:0]  V_FRAME    = 10'(V_TOTAL);
    localparam logic [7:0]  GOOD_LOCK  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  good;
    logic [7:0]  good_nx;
    logic [7:0]  good_inc;
    logic [10:0] hcnt;
    logic [10:0] hcnt_nx;
    logic [9:0]  vline;
    logic [9:0]  vline_nx;
    logic [9:0]  x_nx;
    logic [9:0]  y_nx;
    logic        hs_prev;
    logic        vs_prev;
    logic        h_seen;
    logic        v_seen;
    logic        h_edge;
    logic        v_edge;
    logic        line_err;
    logic        frame_err;
    logic        tick_err;
    logic        active;

    assign locked = (state == LOCKED);

    // Edge detection, next counter values and the timing checks for the current tick.
    // A line/frame measurement is only trusted once a previous edge has been seen.
    always_comb begin
        h_edge = (hsync == SYNC_POL) && (hs_prev != SYNC_POL);
        v_edge = (vsync == SYNC_POL) && (vs_prev != SYNC_POL);

        hcnt_nx = hcnt;
        if (h_edge) begin
            hcnt_nx = '0;
        end else if (hcnt != 11'h7FF) begin
            hcnt_nx = hcnt + 11'd1;
        end

        // A vsync edge on the same tick as an hsync edge starts the frame on line 1.
        vline_nx = vline;
        if (v_edge) begin
            vline_nx = h_edge ? 10'd1 : 10'd0;
        end else if (h_edge && (vline != 10'h3FF)) begin
            vline_nx = vline + 10'd1;
        end

        line_err  = p_tick && h_edge && h_seen && (hcnt != H_LINE_END);
        frame_err = p_tick && v_edge && v_seen && (vline != V_FRAME);
        tick_err  = (line_err || frame_err) && (state != SEARCH);

        active = p_tick &&
                 (hcnt_nx >= H_FIRST) && (hcnt_nx <= H_LAST) &&
                 (vline_nx >= V_FIRST) && (vline_nx <= V_LAST);
        x_nx   = 10'(hcnt_nx - H_FIRST);
        y_nx   = vline_nx - V_FIRST;
    end

    // Lock FSM next state: acquire on a vsync edge, count clean frames, drop on any error.
    always_comb begin
        state_nx = state;
        good_nx  = good;
        good_inc = good + 8'd1;
        if (p_tick) begin
            case (state)
                SEARCH: begin
                    if (v_edge) begin
                        state_nx = TRACK;
                        good_nx  = '0;
                    end
                end
                TRACK, LOCKED: begin
                    if (tick_err) begin
                        state_nx = SEARCH;
                        good_nx  = '0;
                    end else if ((state == TRACK) && v_edge && v_seen) begin
                        good_nx = good_inc;
                        if (good_inc >= GOOD_LOCK) begin
                            state_nx = LOCKED;
                        end
                    end
                end
                default: begin
                    state_nx = SEARCH;
                    good_nx  = '0;
                end
            endcase
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_nx;
            good  <= good_nx;
        end
    end

    // Tick-qualified counters, sync history, error accounting and pixel capture.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            hs_prev     <= ~SYNC_POL;
            vs_prev     <= ~SYNC_POL;
            hcnt        <= '0;
            vline       <= '0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            pix_rgb     <= '0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (p_tick) begin
                hs_prev <= hsync;
                vs_prev <= vsync;
                hcnt    <= hcnt_nx;
                vline   <= vline_nx;

                // Falling back to SEARCH discards line/frame history.
                if (tick_err) begin
                    h_seen <= 1'b0;
                    v_seen <= 1'b0;
                end else begin
                    if (h_edge) h_seen <= 1'b1;
                    if (v_edge) v_seen <= 1'b1;
                end

                if (tick_err) begin
                    err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end

                if (active && (state == LOCKED) && !tick_err) begin
                    pix_valid   <= 1'b1;
                    x           <= x_nx;
                    y           <= y_nx;
                    pix_rgb     <= rgb_in;
                    frame_start <= (x_nx == 10'd0) && (y_nx == 10'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - table-driven checks of sync decode, lock, capture and error handling
module tb_vga_sync_decoder;

    localparam int H_ACTIVE  = 8;
    localparam int H_TOTAL   = 16;
    localparam int H_SYNC    = 2;
    localparam int H_POST    = 2;
    localparam int V_ACTIVE  = 4;
    localparam int V_TOTAL   = 8;
    localparam int V_SYNC    = 1;
    localparam int V_POST    = 2;
    localparam int H_START   = H_SYNC + H_POST;
    localparam int V_START   = V_SYNC + V_POST;
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b0;
    logic        p_tick     = 1'b0;
    logic        hsync      = 1'b0;
    logic        vsync      = 1'b0;
    logic [11:0] rgb_in     = '0;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] pix_rgb;
    logic        pix_valid;
    logic        frame_start;
    logic        locked;
    logic        err;
    logic [7:0]  err_cnt;

    vga_sync_decoder #(
        .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_POST(H_POST),
        .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_POST(V_POST),
        .SYNC_POL(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .p_tick(p_tick),
        .hsync(hsync),
        .vsync(vsync),
        .rgb_in(rgb_in),
        .x(x),
        .y(y),
        .pix_rgb(pix_rgb),
        .pix_valid(pix_valid),
        .frame_start(frame_start),
        .locked(locked),
        .err(err),
        .err_cnt(err_cnt)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        string name;
        int    stall;       // hold p_tick low for 1000 clocks with toggling syncs first
        int    short_line;  // line shortened by one tick, -1 for none
        int    exp_pix;
        bit    exp_lk0;     // locked one clock after the frame's vsync edge tick
        bit    exp_lk;      // locked at end of frame
        int    exp_errs;
    } phase_t;

    phase_t ph[12];

    int n_vec   = 0;
    int n_miss  = 0;
    int div     = 4;
    int n_pix   = 0;
    int n_stray = 0;
    bit lk_at_tick;
    bit lk0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({x, y, pix_rgb, pix_valid, frame_start, locked, err, err_cnt});
    endfunction

    // One pixel tick of a frame whose vsync edge coincides with the line-0 hsync edge,
    // so line l of the frame is counted as vline l+1.
    task automatic tick(input int line, input int t);
        int          xi;
        int          yi;
        bit          act;
        logic [9:0]  xe;
        logic [9:0]  ye;
        logic [11:0] rgb_e;
        logic [63:0] exp;
        xi    = t - H_START;
        yi    = line + 1 - V_START;
        act   = (xi >= 0) && (xi < H_ACTIVE) && (yi >= 0) && (yi < V_ACTIVE);
        xe    = 10'(xi);
        ye    = 10'(yi);
        rgb_e = {xe[3:0], ye[3:0], 4'hA};
        p_tick = 1'b1;
        hsync  = (t < H_SYNC);
        vsync  = (line < V_SYNC);
        rgb_in = rgb_e;
        @(negedge clk_100MHz);
        p_tick     = 1'b0;
        lk_at_tick = locked;
        if (pix_valid) begin
            n_pix++;
            exp = act ? {31'b0, ((xi == 0) && (yi == 0)), ye, xe, rgb_e} : '1;
            check("pix", {31'b0, frame_start, y, x, pix_rgb}, exp);
        end
        repeat (div - 1) begin
            @(negedge clk_100MHz);
            if (pix_valid) n_stray++;
        end
    endtask

    task automatic frame(input int nlines, input int short_line);
        for (int l = 0; l < nlines; l++) begin
            for (int t = 0; t < ((l == short_line) ? H_TOTAL - 1 : H_TOTAL); t++) begin
                tick(l, t);
                if ((l == 0) && (t == 0)) lk0 = lk_at_tick;
            end
        end
    endtask

    task automatic run_phase(input phase_t p);
        n_pix   = 0;
        n_stray = 0;
        if (p.stall != 0) begin
            repeat (1000) begin
                @(negedge clk_100MHz);
                hsync = 1'($urandom_range(0, 1));
                vsync = 1'($urandom_range(0, 1));
                if (pix_valid || frame_start || !locked) n_stray++;
            end
        end
        frame(V_TOTAL, p.short_line);
        check({p.name, "_pix_count"}, 64'(n_pix), 64'(p.exp_pix));
        check({p.name, "_stray"}, 64'(n_stray), 64'd0);
        check({p.name, "_locked_at_edge"}, 64'(lk0), 64'(p.exp_lk0));
        check({p.name, "_locked_end"}, 64'(locked), 64'(p.exp_lk));
        check({p.name, "_err_cnt"}, 64'(err_cnt), 64'(p.exp_errs));
        check({p.name, "_err"}, 64'(err), 64'(p.exp_errs != 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        ph[0]  = '{"acq1",   0, -1, 0,         1'b0, 1'b0, 0};
        ph[1]  = '{"acq2",   0, -1, 0,         1'b0, 1'b0, 0};
        ph[2]  = '{"lock",   0, -1, FRAME_PIX, 1'b1, 1'b1, 0};
        ph[3]  = '{"steady", 0, -1, FRAME_PIX, 1'b1, 1'b1, 0};
        ph[4]  = '{"short",  0,  4, 24,        1'b1, 1'b0, 1};
        ph[5]  = '{"re1",    0, -1, 0,         1'b0, 1'b0, 1};
        ph[6]  = '{"re2",    0, -1, 0,         1'b0, 1'b0, 1};
        ph[7]  = '{"re3",    0, -1, FRAME_PIX, 1'b1, 1'b1, 1};
        ph[8]  = '{"stall",  1, -1, FRAME_PIX, 1'b1, 1'b1, 1};
        ph[9]  = '{"rst_a",  0, -1, 0,         1'b0, 1'b0, 0};
        ph[10] = '{"rst_b",  0, -1, 0,         1'b0, 1'b0, 0};
        ph[11] = '{"rst_c",  0, -1, FRAME_PIX, 1'b1, 1'b1, 0};

        reset = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        check("reset_outputs", outs(), 64'd0);
        reset = 1'b1;

        div = 4;
        for (int i = 0; i < 9; i++) run_phase(ph[i]);

        // Reset mid-frame while locked and while a pixel strobe is high.
        div = 1;
        for (int l = 0; l < 3; l++) begin
            for (int t = 0; t < H_TOTAL; t++) tick(l, t);
        end
        for (int t = 0; t <= 6; t++) tick(3, t);
        check("pre_reset_pix_valid", 64'(pix_valid), 64'd1);
        check("pre_reset_locked", 64'(locked), 64'd1);
        reset = 1'b0;
        #1;
        check("reset_async", outs(), 64'd0);
        repeat (3) @(negedge clk_100MHz);
        check("reset_hold", outs(), 64'd0);
        reset = 1'b1;
        for (int i = 9; i < 12; i++) run_phase(ph[i]);

        // Short frames alternate SEARCH->TRACK and a frame error: two frames per counted error.
        reset = 1'b0;
        @(negedge clk_100MHz);
        reset = 1'b1;
        n_pix = 0;
        for (int f = 0; f < 520; f++) begin
            frame(2, -1);
            if (f == 507) check("err_cnt_254", 64'(err_cnt), 64'd254);
        end
        check("err_cnt_sat", 64'(err_cnt), 64'd255);
        check("err_sat", 64'(err), 64'd1);
        check("sat_locked", 64'(locked), 64'd0);
        check("sat_pix", 64'(n_pix), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
